pe_resp_backroute: RTL and testbench

- Slave-side response router for the peripheral interconnect: one instance sits between the arbitration-tree root and one peripheral slave.
- Records the one-hot master ID of every granted request in an in-order FIFO.
- When the slave returns a response, pops the oldest ID and drives the registered response back to exactly that master's response port.
- Complements the per-master request decoder: requests fan out by address, responses return by ID.

---
 rtl/pe_interco_pkg.sv | 16 +
 rtl/pe_resp_id_fifo.sv | 66 ++++++
 rtl/pe_resp_backroute.sv | 97 +++++++++
 tb/tb_pe_resp_backroute.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_interco_pkg.sv
// rtl/pe_interco_pkg.sv - shared types and helpers for the peripheral interconnect
//
// Purpose: master ID type and one-hot check used by the response back-router.
// Ports:   none (package).
package pe_interco_pkg;

  localparam int N_MASTER = 16;

  typedef logic [N_MASTER-1:0] master_id_t;

  // True when exactly one bit of the ID is set.
  function automatic logic is_onehot(master_id_t id);
    return (id != '0) && ((id & (id - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/pe_resp_id_fifo.sv
// rtl/pe_resp_id_fifo.sv - in-order FIFO of granted master IDs
//
// Purpose: stores the ID of each granted request until its response pops it.
// Ports:   clk, rst (sync, active-high)
//          push_i/data_i   write at tail
//          pop_i/data_o    read at head (data_o is the current head, combinational)
//          full_o/empty_o  occupancy flags
//          usage_o         occupancy count
module pe_resp_id_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] usage_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    usage;

  logic do_push;
  logic do_pop;

  assign full_o  = (usage == CW'(DEPTH));
  assign empty_o = (usage == '0);
  assign usage_o = usage;
  assign data_o  = mem[rptr];

  // Guard locally so the FIFO never corrupts itself even if the caller does not.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      usage <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   usage <= usage + 1'b1;
        2'b01:   usage <= usage - 1'b1;
        default: usage <= usage;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= data_i;
  end

endmodule

// File: rtl/pe_resp_backroute.sv
// rtl/pe_resp_backroute.sv - slave-side response router back to the granting master
//
// Purpose: records the one-hot ID of each granted request and steers the slave's
//          registered response to that master, strictly in grant order.
// Ports:   clk, rst (sync, active-high)
//          data_req_i/data_ID_i/data_gnt_o   arbitration-tree side request
//          data_req_o/data_gnt_i             slave side request
//          data_r_valid_i/_rdata_i/_opc_i    slave response
//          data_r_valid_o/_rdata_o/_opc_o    per-master response (valid is one-hot)
//          outstanding_o                     ID FIFO occupancy
//          err_o                             sticky protocol error
module pe_resp_backroute #(
  parameter int N_MASTER        = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 data_req_i,
  input  logic [N_MASTER-1:0]                  data_ID_i,
  output logic                                 data_gnt_o,
  output logic                                 data_req_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                data_r_rdata_i,
  input  logic                                 data_r_opc_i,
  output logic [N_MASTER-1:0]                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 data_r_opc_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  import pe_interco_pkg::is_onehot;

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [N_MASTER-1:0] head_id;
  logic                id_onehot;

  // Full comes only from registered occupancy, so a same-cycle response never
  // reopens the request path; that costs one cycle at full but avoids a
  // combinational path from the slave response to the slave request.
  assign data_req_o = data_req_i & ~full;
  assign data_gnt_o = data_gnt_i & ~full;

  assign push = data_req_o & data_gnt_i;
  assign pop  = data_r_valid_i & ~empty;

  if (N_MASTER == pe_interco_pkg::N_MASTER) begin : g_pkg_onehot
    assign id_onehot = is_onehot(data_ID_i);
  end else begin : g_gen_onehot
    assign id_onehot = (data_ID_i != '0) && ((data_ID_i & (data_ID_i - 1'b1)) == '0);
  end

  pe_resp_id_fifo #(
    .WIDTH (N_MASTER),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (data_ID_i),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (outstanding_o)
  );

  // Valid pulses for one cycle per pop; data and opc hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r_valid_o <= '0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= 1'b0;
    end else begin
      data_r_valid_o <= pop ? head_id : '0;
      if (pop) begin
        data_r_rdata_o <= data_r_rdata_i;
        data_r_opc_o   <= data_r_opc_i;
      end
    end
  end

  // Orphan responses and malformed IDs are both flagged; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if ((data_r_valid_i & empty) | (push & ~id_onehot)) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_resp_backroute.sv
// tb/tb_pe_resp_backroute.sv - directed self-checking bench for pe_resp_backroute
module tb_pe_resp_backroute;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i;
  logic [15:0] data_ID_i;
  logic        data_gnt_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_r_valid_i;
  logic [31:0] data_r_rdata_i;
  logic        data_r_opc_i;
  logic [15:0] data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        data_r_opc_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_resp_backroute #(
    .N_MASTER        (16),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_req_i     (data_req_i),
    .data_ID_i      (data_ID_i),
    .data_gnt_o     (data_gnt_o),
    .data_req_o     (data_req_o),
    .data_gnt_i     (data_gnt_i),
    .data_r_valid_i (data_r_valid_i),
    .data_r_rdata_i (data_r_rdata_i),
    .data_r_opc_i   (data_r_opc_i),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_req_i     = 1'b0;
    data_gnt_i     = 1'b0;
    data_ID_i      = '0;
    data_r_valid_i = 1'b0;
  endtask

  task automatic grant(input logic [15:0] id);
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    data_ID_i  = id;
    tick();
    data_req_i = 1'b0;
    data_gnt_i = 1'b0;
    data_ID_i  = '0;
  endtask

  task automatic respond(input logic [31:0] rdata, input logic opc);
    data_r_valid_i = 1'b1;
    data_r_rdata_i = rdata;
    data_r_opc_i   = opc;
    tick();
    data_r_valid_i = 1'b0;
  endtask

  initial begin
    idle();
    data_r_rdata_i = '0;
    data_r_opc_i   = 1'b0;
    rst            = 1'b1;
    #1;
    tick();
    tick();
    chk("reset_outstanding", 64'(outstanding_o), 64'd0);
    chk("reset_valid",       64'(data_r_valid_o), 64'h0);
    chk("reset_rdata",       64'(data_r_rdata_o), 64'h0);
    chk("reset_opc",         64'(data_r_opc_o), 64'd0);
    chk("reset_err",         64'(err_o), 64'd0);
    rst = 1'b0;

    // Single read: grant, one idle cycle, response, valid one cycle later.
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    data_ID_i  = 16'h0004;
    #1;
    chk("single_req_o", 64'(data_req_o), 64'd1);
    chk("single_gnt_o", 64'(data_gnt_o), 64'd1);
    tick();
    idle();
    chk("single_outstanding1", 64'(outstanding_o), 64'd1);
    tick();
    respond(32'hDEADBEEF, 1'b0);
    chk("single_valid", 64'(data_r_valid_o), 64'h0004);
    chk("single_rdata", 64'(data_r_rdata_o), 64'hDEADBEEF);
    chk("single_outstanding0", 64'(outstanding_o), 64'd0);
    tick();
    chk("single_valid_drop", 64'(data_r_valid_o), 64'h0);
    chk("single_rdata_hold", 64'(data_r_rdata_o), 64'hDEADBEEF);

    // Ordering across three masters.
    grant(16'h0001);
    grant(16'h0100);
    grant(16'h8000);
    chk("order_outstanding3", 64'(outstanding_o), 64'd3);
    respond(32'hAAAA0001, 1'b0);
    chk("order_valid_a", 64'(data_r_valid_o), 64'h0001);
    chk("order_rdata_a", 64'(data_r_rdata_o), 64'hAAAA0001);
    respond(32'hBBBB0002, 1'b1);
    chk("order_valid_b", 64'(data_r_valid_o), 64'h0100);
    chk("order_rdata_b", 64'(data_r_rdata_o), 64'hBBBB0002);
    chk("order_opc_b",   64'(data_r_opc_o), 64'd1);
    respond(32'hCCCC0003, 1'b0);
    chk("order_valid_c", 64'(data_r_valid_o), 64'h8000);
    chk("order_rdata_c", 64'(data_r_rdata_o), 64'hCCCC0003);
    chk("order_opc_c",   64'(data_r_opc_o), 64'd0);
    chk("order_outstanding0", 64'(outstanding_o), 64'd0);

    // Fill to depth 4, then hold the request against a full FIFO.
    grant(16'h0001);
    grant(16'h0002);
    grant(16'h0004);
    grant(16'h0008);
    chk("full_outstanding4", 64'(outstanding_o), 64'd4);
    data_req_i = 1'b1;
    data_gnt_i = 1'b1;
    data_ID_i  = 16'h0010;
    #1;
    chk("full_req_o", 64'(data_req_o), 64'd0);
    chk("full_gnt_o", 64'(data_gnt_o), 64'd0);
    // A response in the full cycle pops but does not admit the waiting request.
    respond(32'h11112222, 1'b0);
    chk("full_pop_valid", 64'(data_r_valid_o), 64'h0001);
    chk("full_outstanding3", 64'(outstanding_o), 64'd3);
    chk("full_reopen_req_o", 64'(data_req_o), 64'd1);
    chk("full_reopen_gnt_o", 64'(data_gnt_o), 64'd1);
    tick();
    idle();
    chk("full_regrant_outstanding4", 64'(outstanding_o), 64'd4);

    // Drain to occupancy 2 (0x0008, 0x0010 remain), then push and pop together.
    respond(32'h0, 1'b0);
    chk("drain_valid_2", 64'(data_r_valid_o), 64'h0002);
    respond(32'h0, 1'b0);
    chk("drain_valid_4", 64'(data_r_valid_o), 64'h0004);
    chk("drain_outstanding2", 64'(outstanding_o), 64'd2);
    data_req_i     = 1'b1;
    data_gnt_i     = 1'b1;
    data_ID_i      = 16'h0020;
    data_r_valid_i = 1'b1;
    data_r_rdata_i = 32'h5A5A5A5A;
    tick();
    idle();
    chk("simul_valid_oldest", 64'(data_r_valid_o), 64'h0008);
    chk("simul_outstanding2", 64'(outstanding_o), 64'd2);
    respond(32'h1, 1'b0);
    chk("simul_valid_next", 64'(data_r_valid_o), 64'h0010);
    respond(32'h2, 1'b0);
    chk("simul_valid_pushed", 64'(data_r_valid_o), 64'h0020);
    chk("simul_outstanding0", 64'(outstanding_o), 64'd0);
    chk("no_err_so_far", 64'(err_o), 64'd0);

    // Response with an empty FIFO: dropped and flagged, error sticks.
    respond(32'hBAD0BAD0, 1'b1);
    chk("orphan_valid", 64'(data_r_valid_o), 64'h0);
    chk("orphan_rdata_hold", 64'(data_r_rdata_o), 64'h2);
    chk("orphan_err", 64'(err_o), 64'd1);
    tick();
    tick();
    chk("orphan_err_sticky", 64'(err_o), 64'd1);

    // Malformed IDs after a clean reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset2_err", 64'(err_o), 64'd0);
    grant(16'h0003);
    chk("multibit_err", 64'(err_o), 64'd1);
    chk("multibit_outstanding1", 64'(outstanding_o), 64'd1);
    grant(16'h0000);
    respond(32'h3, 1'b0);
    chk("multibit_valid", 64'(data_r_valid_o), 64'h0003);
    respond(32'h4, 1'b0);
    chk("zero_id_valid", 64'(data_r_valid_o), 64'h0000);
    chk("zero_id_rdata", 64'(data_r_rdata_o), 64'h4);
    chk("zero_id_outstanding0", 64'(outstanding_o), 64'd0);

    // Reset mid-operation with three outstanding and a response in flight.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    grant(16'h0001);
    grant(16'h0002);
    grant(16'h0004);
    data_r_valid_i = 1'b1;
    data_r_rdata_i = 32'h77777777;
    tick();
    data_r_valid_i = 1'b0;
    chk("midop_pre_valid", 64'(data_r_valid_o), 64'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midop_rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("midop_rst_valid", 64'(data_r_valid_o), 64'h0);
    chk("midop_rst_err", 64'(err_o), 64'd0);
    respond(32'h99999999, 1'b0);
    chk("midop_orphan_valid", 64'(data_r_valid_o), 64'h0);
    chk("midop_orphan_err", 64'(err_o), 64'd1);
    chk("midop_orphan_outstanding", 64'(outstanding_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
